// File: rtl/traffic_safety_monitor_if.sv
// Light-vector bundle between the traffic controller and the safety monitor.
// The master side is the controller (or a bench); the slave side is the monitor.
interface traffic_safety_monitor_if;
   logic [2:0] i_h_car;
   logic [2:0] i_h_walker;
   logic [2:0] i_v_car;
   logic [2:0] i_v_walker;
   logic       i_clear;
   logic [2:0] o_h_car;
   logic [2:0] o_h_walker;
   logic [2:0] o_v_car;
   logic [2:0] o_v_walker;
   logic       o_fault;
   logic [2:0] o_fault_code;
   logic [7:0] o_fault_count;

   modport master (
      output i_h_car, i_h_walker, i_v_car, i_v_walker, i_clear,
      input  o_h_car, o_h_walker, o_v_car, o_v_walker,
      input  o_fault, o_fault_code, o_fault_count
   );

   modport slave (
      input  i_h_car, i_h_walker, i_v_car, i_v_walker, i_clear,
      output o_h_car, o_h_walker, o_v_car, o_v_walker,
      output o_fault, o_fault_code, o_fault_count
   );
endinterface

// File: rtl/traffic_safety_monitor.sv
// Safety checker sitting between the traffic controller and the lamp drivers.
// Registers the four light vectors and replaces them with all-red whenever an
// illegal encoding, right-of-way conflict, bad colour sequence or short dwell
// is seen. The fault is latched until software clears it on a clean cycle.
module traffic_safety_monitor #(
   parameter int unsigned MIN_GREEN  = 4,
   parameter int unsigned MIN_YELLOW = 2
) (
   input logic                     clk,
   input logic                     reset,
   traffic_safety_monitor_if.slave bus
);

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   localparam logic [7:0] MIN_GREEN_W  = 8'(MIN_GREEN);
   localparam logic [7:0] MIN_YELLOW_W = 8'(MIN_YELLOW);

   localparam logic [2:0] CODE_NONE          = 3'd0;
   localparam logic [2:0] CODE_ILLEGAL_ENC   = 3'd1;
   localparam logic [2:0] CODE_CAR_CONFLICT  = 3'd2;
   localparam logic [2:0] CODE_WALK_CONFLICT = 3'd3;
   localparam logic [2:0] CODE_BAD_SEQ       = 3'd4;
   localparam logic [2:0] CODE_SHORT_GREEN   = 3'd5;
   localparam logic [2:0] CODE_SHORT_YELLOW  = 3'd6;

   typedef enum logic {
      MONITOR,
      FAULT
   } state_t;

   state_t     state_q;
   logic [2:0] hCarOut_q;
   logic [2:0] hWalkerOut_q;
   logic [2:0] vCarOut_q;
   logic [2:0] vWalkerOut_q;
   logic       fault_q;
   logic [2:0] faultCode_q;
   logic [7:0] faultCount_q;

   logic [2:0] hPrev_q, hPrev_d;
   logic [2:0] vPrev_q, vPrev_d;
   logic [7:0] hDwell_q, hDwell_d;
   logic [7:0] vDwell_q, vDwell_d;

   logic       hCarOneHot;
   logic       vCarOneHot;
   logic       allOneHot;
   logic [2:0] hSeqCode;
   logic [2:0] vSeqCode;
   logic [2:0] violCode;

   function automatic logic isOneHot(input logic [2:0] v);
      return (v == RED) || (v == YELLOW) || (v == GREEN);
   endfunction

   function automatic logic [2:0] seqCheck(input logic [2:0] cur,
                                           input logic [2:0] prev,
                                           input logic [7:0] dwell);
      logic [2:0] code;
      code = CODE_NONE;
      if (cur != prev) begin
         if (!((prev == RED && cur == GREEN) ||
               (prev == GREEN && cur == YELLOW) ||
               (prev == YELLOW && cur == RED))) begin
            code = CODE_BAD_SEQ;
         end else if (prev == GREEN && dwell < MIN_GREEN_W) begin
            code = CODE_SHORT_GREEN;
         end else if (prev == YELLOW && dwell < MIN_YELLOW_W) begin
            code = CODE_SHORT_YELLOW;
         end
      end
      return code;
   endfunction

   // Classify the current inputs; when several checks fire the lowest code is reported
   always_comb begin
      hCarOneHot = isOneHot(bus.i_h_car);
      vCarOneHot = isOneHot(bus.i_v_car);
      allOneHot  = hCarOneHot && vCarOneHot &&
                   isOneHot(bus.i_h_walker) && isOneHot(bus.i_v_walker);
      hSeqCode   = hCarOneHot ? seqCheck(bus.i_h_car, hPrev_q, hDwell_q) : CODE_NONE;
      vSeqCode   = vCarOneHot ? seqCheck(bus.i_v_car, vPrev_q, vDwell_q) : CODE_NONE;
      violCode   = CODE_NONE;
      if (!allOneHot) begin
         violCode = CODE_ILLEGAL_ENC;
      end else if (bus.i_h_car != RED && bus.i_v_car != RED) begin
         violCode = CODE_CAR_CONFLICT;
      end else if ((bus.i_h_walker == GREEN && bus.i_v_car != RED) ||
                   (bus.i_v_walker == GREEN && bus.i_h_car != RED)) begin
         violCode = CODE_WALK_CONFLICT;
      end else if (hSeqCode != CODE_NONE &&
                   (vSeqCode == CODE_NONE || hSeqCode <= vSeqCode)) begin
         violCode = hSeqCode;
      end else begin
         violCode = vSeqCode;
      end
   end

   // Next colour history and dwell per car light; garbage inputs leave history untouched
   always_comb begin
      hPrev_d  = hPrev_q;
      hDwell_d = hDwell_q;
      vPrev_d  = vPrev_q;
      vDwell_d = vDwell_q;
      if (hCarOneHot) begin
         if (bus.i_h_car != hPrev_q) begin
            hPrev_d  = bus.i_h_car;
            hDwell_d = 8'd1;
         end else if (hDwell_q != 8'hFF) begin
            hDwell_d = hDwell_q + 8'd1;
         end
      end
      if (vCarOneHot) begin
         if (bus.i_v_car != vPrev_q) begin
            vPrev_d  = bus.i_v_car;
            vDwell_d = 8'd1;
         end else if (vDwell_q != 8'hFF) begin
            vDwell_d = vDwell_q + 8'd1;
         end
      end
   end

   // Colour history registers; dwell starts saturated so the first departure is never short
   always_ff @(posedge clk) begin
      if (reset) begin
         hPrev_q  <= RED;
         vPrev_q  <= RED;
         hDwell_q <= 8'hFF;
         vDwell_q <= 8'hFF;
      end else begin
         hPrev_q  <= hPrev_d;
         vPrev_q  <= vPrev_d;
         hDwell_q <= hDwell_d;
         vDwell_q <= vDwell_d;
      end
   end

   // Monitor/fault state machine with registered lamp drives, fault code and entry count
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= MONITOR;
         hCarOut_q    <= RED;
         hWalkerOut_q <= RED;
         vCarOut_q    <= RED;
         vWalkerOut_q <= RED;
         fault_q      <= 1'b0;
         faultCode_q  <= CODE_NONE;
         faultCount_q <= 8'd0;
      end else begin
         case (state_q)
            MONITOR: begin
               if (violCode != CODE_NONE) begin
                  state_q      <= FAULT;
                  hCarOut_q    <= RED;
                  hWalkerOut_q <= RED;
                  vCarOut_q    <= RED;
                  vWalkerOut_q <= RED;
                  fault_q      <= 1'b1;
                  faultCode_q  <= violCode;
                  if (faultCount_q != 8'hFF) begin
                     faultCount_q <= faultCount_q + 8'd1;
                  end
               end else begin
                  hCarOut_q    <= bus.i_h_car;
                  hWalkerOut_q <= bus.i_h_walker;
                  vCarOut_q    <= bus.i_v_car;
                  vWalkerOut_q <= bus.i_v_walker;
               end
            end
            FAULT: begin
               hCarOut_q    <= RED;
               hWalkerOut_q <= RED;
               vCarOut_q    <= RED;
               vWalkerOut_q <= RED;
               if (bus.i_clear && violCode == CODE_NONE) begin
                  state_q     <= MONITOR;
                  fault_q     <= 1'b0;
                  faultCode_q <= CODE_NONE;
               end
            end
            default: begin
               state_q <= MONITOR;
            end
         endcase
      end
   end

   assign bus.o_h_car       = hCarOut_q;
   assign bus.o_h_walker    = hWalkerOut_q;
   assign bus.o_v_car       = vCarOut_q;
   assign bus.o_v_walker    = vWalkerOut_q;
   assign bus.o_fault       = fault_q;
   assign bus.o_fault_code  = faultCode_q;
   assign bus.o_fault_count = faultCount_q;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Self-checking bench for traffic_safety_monitor: directed scenarios followed by
// a randomized run, all compared against a colour-index reference model.
module tb_traffic_safety_monitor;

   localparam int MIN_GREEN  = 4;
   localparam int MIN_YELLOW = 2;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   traffic_safety_monitor_if busIf ();

   traffic_safety_monitor #(
      .MIN_GREEN  (MIN_GREEN),
      .MIN_YELLOW (MIN_YELLOW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: colours kept as indices 0=red, 1=green, 2=yellow,
   // so the only legal move is to index (prev+1) mod 3
   logic [2:0] expLights [4];
   logic       expFault;
   int         expCode;
   int         expCount;
   int         refPrev [2];
   int         refDwell [2];

   function automatic int colourOf(input logic [2:0] v);
      case (v)
         3'b100:  return 0;
         3'b001:  return 1;
         3'b010:  return 2;
         default: return -1;
      endcase
   endfunction

   function automatic logic [2:0] bitsOf(input int c);
      case (c)
         0:       return 3'b100;
         1:       return 3'b001;
         default: return 3'b010;
      endcase
   endfunction

   function automatic int carRule(input int cur, input int prev, input int dwell);
      if (cur == prev) return 0;
      if (cur != (prev + 1) % 3) return 4;
      if (prev == 1 && dwell < MIN_GREEN) return 5;
      if (prev == 2 && dwell < MIN_YELLOW) return 6;
      return 0;
   endfunction

   function automatic int refCode(input logic [2:0] h, input logic [2:0] hw,
                                  input logic [2:0] v, input logic [2:0] vw);
      int hc, hwc, vc, vwc, a, b;
      hc  = colourOf(h);
      hwc = colourOf(hw);
      vc  = colourOf(v);
      vwc = colourOf(vw);
      if (hc < 0 || hwc < 0 || vc < 0 || vwc < 0) return 1;
      if (hc != 0 && vc != 0) return 2;
      if ((hwc == 1 && vc != 0) || (vwc == 1 && hc != 0)) return 3;
      a = carRule(hc, refPrev[0], refDwell[0]);
      b = carRule(vc, refPrev[1], refDwell[1]);
      if (a == 0) return b;
      if (b == 0) return a;
      return (a < b) ? a : b;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 4; i++) expLights[i] = R;
      expFault = 1'b0;
      expCode  = 0;
      expCount = 0;
      for (int i = 0; i < 2; i++) begin
         refPrev[i]  = 0;
         refDwell[i] = 255;
      end
   endtask

   task automatic modelEdge(input logic [2:0] h, input logic [2:0] hw,
                            input logic [2:0] v, input logic [2:0] vw,
                            input logic clr, input logic rst);
      int code;
      int cols [2];
      if (rst) begin
         modelReset();
         return;
      end
      code = refCode(h, hw, v, vw);
      if (!expFault) begin
         if (code != 0) begin
            expFault = 1'b1;
            expCode  = code;
            if (expCount < 255) expCount++;
            for (int i = 0; i < 4; i++) expLights[i] = R;
         end else begin
            expLights[0] = h;
            expLights[1] = hw;
            expLights[2] = v;
            expLights[3] = vw;
         end
      end else begin
         for (int i = 0; i < 4; i++) expLights[i] = R;
         if (clr && code == 0) begin
            expFault = 1'b0;
            expCode  = 0;
         end
      end
      cols[0] = colourOf(h);
      cols[1] = colourOf(v);
      for (int i = 0; i < 2; i++) begin
         if (cols[i] >= 0) begin
            if (cols[i] != refPrev[i]) begin
               refPrev[i]  = cols[i];
               refDwell[i] = 1;
            end else if (refDwell[i] < 255) begin
               refDwell[i]++;
            end
         end
      end
   endtask

   // One comparison point: counts the vector and reports any difference
   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compare every DUT output against the reference model
   task automatic checkOutput();
      check("o_h_car",       8'(busIf.o_h_car),       8'(expLights[0]));
      check("o_h_walker",    8'(busIf.o_h_walker),    8'(expLights[1]));
      check("o_v_car",       8'(busIf.o_v_car),       8'(expLights[2]));
      check("o_v_walker",    8'(busIf.o_v_walker),    8'(expLights[3]));
      check("o_fault",       8'(busIf.o_fault),       8'(expFault));
      check("o_fault_code",  8'(busIf.o_fault_code),  8'(expCode));
      check("o_fault_count", busIf.o_fault_count,     8'(expCount));
   endtask

   // Drive one cycle of inputs away from the edge, advance the model, then check
   task automatic applyStimulus(input logic [2:0] h, input logic [2:0] hw,
                                input logic [2:0] v, input logic [2:0] vw,
                                input logic clr, input logic rst);
      @(negedge clk);
      busIf.i_h_car    = h;
      busIf.i_h_walker = hw;
      busIf.i_v_car    = v;
      busIf.i_v_walker = vw;
      busIf.i_clear    = clr;
      reset            = rst;
      @(posedge clk);
      modelEdge(h, hw, v, vw, clr, rst);
      #1;
      checkOutput();
   endtask

   task automatic allRedReset();
      applyStimulus(R, R, R, R, 1'b0, 1'b1);
   endtask

   int         genCol [2];
   logic [2:0] rh, rhw, rv, rvw;
   logic       rclr, rrst;
   int         r;

   // Directed scenarios first, then a randomized run against the model
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      busIf.i_h_car    = R;
      busIf.i_h_walker = R;
      busIf.i_v_car    = R;
      busIf.i_v_walker = R;
      busIf.i_clear    = 1'b0;
      modelReset();

      // Reset values
      allRedReset();
      check("reset_h_car", 8'(busIf.o_h_car), 8'(R));
      check("reset_v_walker", 8'(busIf.o_v_walker), 8'(R));
      check("reset_fault", 8'(busIf.o_fault), 8'd0);
      check("reset_count", busIf.o_fault_count, 8'd0);

      // Legal horizontal cycle with the vertical walker crossing while h_car is red
      applyStimulus(R, R, R, G, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(G, R, R, R, 1'b0, 1'b0);
      check("legal_pass_green", 8'(busIf.o_h_car), 8'(G));
      for (int i = 0; i < 2; i++) applyStimulus(Y, R, R, R, 1'b0, 1'b0);
      applyStimulus(R, R, R, G, 1'b0, 1'b0);
      check("legal_no_fault", 8'(busIf.o_fault), 8'd0);
      check("legal_v_walker", 8'(busIf.o_v_walker), 8'(G));

      // Car conflict
      applyStimulus(G, R, Y, R, 1'b0, 1'b0);
      check("conflict_h_car", 8'(busIf.o_h_car), 8'(R));
      check("conflict_v_car", 8'(busIf.o_v_car), 8'(R));
      check("conflict_fault", 8'(busIf.o_fault), 8'd1);
      check("conflict_code", 8'(busIf.o_fault_code), 8'd2);
      check("conflict_count", busIf.o_fault_count, 8'd1);

      // Illegal encoding outranks walker conflict
      allRedReset();
      applyStimulus(G, R, R, R, 1'b0, 1'b0);
      applyStimulus(G, R, R, 3'b011, 1'b0, 1'b0);
      check("priority_code", 8'(busIf.o_fault_code), 8'd1);

      // Short green
      allRedReset();
      for (int i = 0; i < 3; i++) applyStimulus(G, R, R, R, 1'b0, 1'b0);
      check("short_green_before", 8'(busIf.o_fault), 8'd0);
      applyStimulus(Y, R, R, R, 1'b0, 1'b0);
      check("short_green_code", 8'(busIf.o_fault_code), 8'd5);

      // Bad sequence red to yellow
      allRedReset();
      applyStimulus(R, R, R, R, 1'b0, 1'b0);
      applyStimulus(Y, R, R, R, 1'b0, 1'b0);
      check("bad_seq_code", 8'(busIf.o_fault_code), 8'd4);

      // Clear handling: clear during a walker conflict is ignored
      allRedReset();
      applyStimulus(R, 3'b111, R, R, 1'b0, 1'b0);
      check("clear_entry_code", 8'(busIf.o_fault_code), 8'd1);
      applyStimulus(R, G, G, R, 1'b1, 1'b0);
      check("clear_ignored_fault", 8'(busIf.o_fault), 8'd1);
      check("clear_ignored_count", busIf.o_fault_count, 8'd1);
      check("clear_ignored_code", 8'(busIf.o_fault_code), 8'd1);
      for (int i = 0; i < 3; i++) applyStimulus(R, R, G, R, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(R, R, Y, R, 1'b0, 1'b0);
      applyStimulus(R, R, R, R, 1'b0, 1'b0);
      check("still_fault", 8'(busIf.o_fault), 8'd1);
      applyStimulus(R, R, R, R, 1'b1, 1'b0);
      check("clear_fault", 8'(busIf.o_fault), 8'd0);
      check("clear_code", 8'(busIf.o_fault_code), 8'd0);
      applyStimulus(G, R, R, R, 1'b0, 1'b0);
      check("after_clear_pass", 8'(busIf.o_h_car), 8'(G));
      applyStimulus(G, R, R, R, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(G, R, R, R, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(Y, R, R, R, 1'b0, 1'b0);
      applyStimulus(R, R, R, R, 1'b0, 1'b0);

      // Count saturation over 256 fault/clear pairs
      for (int i = 0; i < 256; i++) begin
         applyStimulus(R, 3'b111, R, R, 1'b0, 1'b0);
         applyStimulus(R, R, R, R, 1'b1, 1'b0);
      end
      check("count_saturated", busIf.o_fault_count, 8'd255);

      // Reset in the middle of a fault
      applyStimulus(R, 3'b111, R, R, 1'b0, 1'b0);
      allRedReset();
      check("mid_reset_count", busIf.o_fault_count, 8'd0);
      check("mid_reset_fault", 8'(busIf.o_fault), 8'd0);
      check("mid_reset_h_car", 8'(busIf.o_h_car), 8'(R));

      // Randomized traffic: cars mostly hold or advance, occasional jumps and garbage
      genCol[0] = 0;
      genCol[1] = 0;
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < 2; c++) begin
            r = int'($urandom_range(0, 99));
            if (r >= 65 && r < 93) genCol[c] = (genCol[c] + 1) % 3;
            else if (r >= 93) genCol[c] = int'($urandom_range(0, 2));
         end
         rh  = bitsOf(genCol[0]);
         rv  = bitsOf(genCol[1]);
         rhw = ($urandom_range(0, 99) < 25) ? G : R;
         rvw = ($urandom_range(0, 99) < 25) ? G : R;
         if ($urandom_range(0, 99) < 4) rh  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 99) < 4) rvw = 3'($urandom_range(0, 7));
         rclr = ($urandom_range(0, 99) < 30);
         rrst = ($urandom_range(0, 199) == 0);
         applyStimulus(rh, rhw, rv, rvw, rclr, rrst);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
